// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB3 bus bundle; master = requester view, slave = environment view
interface apb_master_if #(parameter int ADDR_W = 8, parameter int DATA_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: APB3 requester turning valid/ready commands into SETUP/ACCESS transfers with a one-cycle response pulse
//   PCLK, PRESET (async, active-high); bus: apb_master_if.master carrying cmd_*, rsp_* and PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR
//   Optional: define APB_MASTER_RANGE_CHECK_EN to reject aligned addresses above RANGE_MAX locally
module apb_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int RANGE_MAX = 12
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_master_if.master  bus
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              tmo;
  logic              reject;
`ifdef APB_MASTER_RANGE_CHECK_EN
  assign reject = bus.cmd_addr[1:0] != 2'b00 || bus.cmd_addr > ADDR_W'(RANGE_MAX);
`else
  assign reject = bus.cmd_addr[1:0] != 2'b00;
`endif
  assign bus.cmd_ready   = state == IDLE;
  assign bus.PSEL        = state == SETUP || state == ACCESS;
  assign bus.PENABLE     = state == ACCESS;
  assign bus.PWRITE      = wr;
  assign bus.PADDR       = addr;
  assign bus.PWDATA      = wdata;
  assign bus.rsp_valid   = state == RESP;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = err;
  assign bus.rsp_timeout = tmo;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      err   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          wr    <= bus.cmd_write;
          addr  <= bus.cmd_addr;
          wdata <= bus.cmd_wdata;
          if (reject) begin
            state <= RESP;
            err   <= 1'b1;
            tmo   <= 1'b0;
            rdata <= '0;
          end else state <= SETUP;
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: if (bus.PREADY) begin
          rdata <= (!wr && !bus.PSLVERR) ? bus.PRDATA : '0;
          err   <= bus.PSLVERR;
          tmo   <= 1'b0;
          state <= RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th ACCESS cycle without PREADY; a PREADY here would still have won
          rdata <= '0;
          err   <= 1'b1;
          tmo   <= 1'b1;
          state <= RESP;
        end else cnt <= cnt + CW'(1);
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master
module tb_apb_master;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int errors = 0;
  int checks = 0;
  int lat, nsel, nen;
  apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16), .RANGE_MAX(12)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask
  // called at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen (or after 40 cycles)
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input int waits,
                      input logic [31:0] rd, input logic se, output int l, output int ns, output int ne);
    int k;
    k = 0; l = 0; ns = 0; ne = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    bus.PRDATA = rd; bus.PSLVERR = se; bus.PREADY = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      l = i;
      if (bus.PSEL) ns++;
      if (bus.PENABLE) begin
        bus.PREADY = (k == waits);
        k++;
        ne++;
      end else bus.PREADY = 1'b0;
      if (bus.rsp_valid) break;
      @(negedge PCLK);
    end
    bus.PREADY = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    @(negedge PCLK);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 1, 32'hFFFFFFFF, 1'b0, lat, nsel, nen);
    chk("t1_lat", lat, 4);
    chk("t1_psel_cycles", nsel, 3);
    chk("t1_penable_cycles", nen, 2);
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_err", bus.rsp_err, 0);
    chk("t1_rdata", bus.rsp_rdata, 0);
    chk("t1_cmd_ready_resp", bus.cmd_ready, 0);
    chk("t1_psel_resp", bus.PSEL, 0);
    @(negedge PCLK);
    chk("t1_pulse", bus.rsp_valid, 0);
    chk("t1_paddr_hold", bus.PADDR, 32'h04);
    chk("t1_pwdata_hold", bus.PWDATA, 32'hDEADBEEF);
    chk("t1_cmd_ready_idle", bus.cmd_ready, 1);
    xfer(1'b0, 8'h04, 32'h0, 0, 32'hDEADBEEF, 1'b0, lat, nsel, nen);
    chk("t2_lat", lat, 3);
    chk("t2_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t2_err", bus.rsp_err, 0);
    @(negedge PCLK);
    xfer(1'b1, 8'h08, 32'h11223344, 0, 32'h0, 1'b1, lat, nsel, nen);
    chk("t3_lat", lat, 3);
    chk("t3_err", bus.rsp_err, 1);
    chk("t3_timeout", bus.rsp_timeout, 0);
    @(negedge PCLK);
    xfer(1'b0, 8'h0C, 32'h0, -1, 32'h55555555, 1'b0, lat, nsel, nen);
    chk("t4_penable_cycles", nen, 16);
    chk("t4_lat", lat, 18);
    chk("t4_err", bus.rsp_err, 1);
    chk("t4_timeout", bus.rsp_timeout, 1);
    chk("t4_rdata", bus.rsp_rdata, 0);
    chk("t4_psel", bus.PSEL, 0);
    @(negedge PCLK);
    chk("t4_err_hold", bus.rsp_err, 1);
    chk("t4_timeout_hold", bus.rsp_timeout, 1);
    xfer(1'b0, 8'h0C, 32'h0, 15, 32'hA5A5A5A5, 1'b0, lat, nsel, nen);
    chk("t4b_penable_cycles", nen, 16);
    chk("t4b_lat", lat, 18);
    chk("t4b_timeout", bus.rsp_timeout, 0);
    chk("t4b_err", bus.rsp_err, 0);
    chk("t4b_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
    @(negedge PCLK);
    xfer(1'b0, 8'h06, 32'h0, 0, 32'h77777777, 1'b0, lat, nsel, nen);
    chk("t5_lat", lat, 1);
    chk("t5_psel_cycles", nsel, 0);
    chk("t5_err", bus.rsp_err, 1);
    chk("t5_timeout", bus.rsp_timeout, 0);
    chk("t5_rdata", bus.rsp_rdata, 0);
    @(negedge PCLK);
    xfer(1'b1, 8'h10, 32'hCAFEF00D, 0, 32'h0, 1'b0, lat, nsel, nen);
`ifdef APB_MASTER_RANGE_CHECK_EN
    chk("t5b_lat", lat, 1);
    chk("t5b_psel_cycles", nsel, 0);
    chk("t5b_err", bus.rsp_err, 1);
`else
    chk("t5b_lat", lat, 3);
    chk("t5b_psel_cycles", nsel, 2);
    chk("t5b_err", bus.rsp_err, 0);
`endif
    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h0C; bus.PREADY = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("t6_penable_before", bus.PENABLE, 1);
    #1 PRESET = 1'b1;
    #1;
    chk("t6_psel_async", bus.PSEL, 0);
    chk("t6_penable_async", bus.PENABLE, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_rsp", bus.rsp_valid, 0);
      @(negedge PCLK);
    end
    xfer(1'b0, 8'h04, 32'h0, 0, 32'h12345678, 1'b0, lat, nsel, nen);
    chk("t6_lat", lat, 3);
    chk("t6_rdata", bus.rsp_rdata, 32'h12345678);
    chk("t6_err", bus.rsp_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
